// File: rtl/stopwatch_top.sv
// Stopwatch HH:MM:SS.CC with debounced start/stop and clear, shown on an 8-digit multiplexed display.
// Latency: switch edges act after 2 sync clocks plus DEBOUNCE_TICKS ms; AN/SEG are registered one clock after the scan index.
// Backpressure: none; free-running board-level block driven straight from pins.
module stopwatch_top #(
    parameter int CLK_HZ         = 100000000,
    parameter int TICK_DIV       = 100000,
    parameter int CS_TICKS       = 10,
    parameter int DEBOUNCE_TICKS = 10,
    parameter int REFRESH_TICKS  = 1
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic [15:0] SW,
    output logic [6:0]  SEG,
    output logic [7:0]  AN
);

    localparam int DW = $clog2(TICK_DIV + 1);
    localparam int CW = $clog2(CS_TICKS + 1);
    localparam int BW = $clog2(DEBOUNCE_TICKS + 1);
    localparam int RW = $clog2(REFRESH_TICKS + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CS_LAST  = CW'(CS_TICKS - 1);
    localparam logic [BW-1:0] DB_LAST  = BW'(DEBOUNCE_TICKS - 1);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_TICKS - 1);

    // SW[15:2] are not wired to anything; CLK_HZ documents the board clock only.
    logic unused_ok;
    assign unused_ok = ^{SW[15:2], (CLK_HZ > 0)};

    // ------------------------------------------------------------------
    // Tick generation
    // ------------------------------------------------------------------
    logic [DW-1:0] div_q, div_d;
    logic          clock_1ms, clock_1ms_d;
    logic [RW-1:0] ref_q, ref_d;
    logic          clock_refresh;
    logic [CW-1:0] pre_q, pre_d;
    logic          cs_en;
    logic          running, running_d;
    logic          clear_lvl;

    assign clock_refresh = clock_1ms && (ref_q == REF_LAST);
    assign cs_en         = clock_1ms && running && (pre_q == CS_LAST);

    // Next-state for the ms divider, refresh divider and centisecond prescaler.
    always_comb begin
        div_d       = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        clock_1ms_d = (div_q == DIV_LAST);
        ref_d       = ref_q;
        pre_d       = pre_q;
        if (clock_1ms) begin
            ref_d = (ref_q == REF_LAST) ? '0 : ref_q + 1'b1;
        end
        // Prescaler only advances while running, so a stop/start keeps the partial period.
        if (clear_lvl) begin
            pre_d = '0;
        end else if (clock_1ms && running) begin
            pre_d = (pre_q == CS_LAST) ? '0 : pre_q + 1'b1;
        end
    end

    // Tick-generation state registers.
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            div_q     <= '0;
            clock_1ms <= 1'b0;
            ref_q     <= '0;
            pre_q     <= '0;
        end else begin
            div_q     <= div_d;
            clock_1ms <= clock_1ms_d;
            ref_q     <= ref_d;
            pre_q     <= pre_d;
        end
    end

    // ------------------------------------------------------------------
    // Switch synchronizer and debounce (SW[0] start/stop, SW[1] clear)
    // ------------------------------------------------------------------
    logic [1:0]    sync1_q, sync2_q;
    logic [1:0]    db_q, db_d;
    logic [BW-1:0] dbcnt_q [2];
    logic [BW-1:0] dbcnt_d [2];
    logic          db0_prev_q;
    logic          start_edge;

    assign start_edge = db_q[0] && !db0_prev_q;
    assign clear_lvl  = db_q[1];

    // Accept a new level only after DEBOUNCE_TICKS consecutive differing ms samples.
    always_comb begin
        db_d    = db_q;
        dbcnt_d = dbcnt_q;
        for (int i = 0; i < 2; i++) begin
            if (clock_1ms) begin
                if (sync2_q[i] == db_q[i]) begin
                    dbcnt_d[i] = '0;
                end else if (dbcnt_q[i] == DB_LAST) begin
                    db_d[i]    = sync2_q[i];
                    dbcnt_d[i] = '0;
                end else begin
                    dbcnt_d[i] = dbcnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Synchronizer, debounce and edge-history registers.
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            db_q       <= '0;
            dbcnt_q    <= '{default: '0};
            db0_prev_q <= 1'b0;
        end else begin
            sync1_q    <= SW[1:0];
            sync2_q    <= sync1_q;
            db_q       <= db_d;
            dbcnt_q    <= dbcnt_d;
            db0_prev_q <= db_q[0];
        end
    end

    // ------------------------------------------------------------------
    // Run control and time-of-count registers
    // ------------------------------------------------------------------
    logic [6:0] centiseconds, centiseconds_d;
    logic [5:0] seconds, seconds_d;
    logic [5:0] minutes, minutes_d;
    logic [4:0] hours, hours_d;

    // Clear wins over a start edge; otherwise each debounced rising edge toggles running.
    always_comb begin
        running_d = running;
        if (clear_lvl) begin
            running_d = 1'b0;
        end else if (start_edge) begin
            running_d = !running;
        end
    end

    // Cascaded BCD-free time counters; >= comparisons let any out-of-range value recover.
    always_comb begin
        centiseconds_d = centiseconds;
        seconds_d      = seconds;
        minutes_d      = minutes;
        hours_d        = hours;
        if (clear_lvl) begin
            centiseconds_d = '0;
            seconds_d      = '0;
            minutes_d      = '0;
            hours_d        = '0;
        end else if (cs_en) begin
            if (centiseconds >= 7'd99) begin
                centiseconds_d = '0;
                if (seconds >= 6'd59) begin
                    seconds_d = '0;
                    if (minutes >= 6'd59) begin
                        minutes_d = '0;
                        hours_d   = (hours >= 5'd23) ? 5'd0 : hours + 5'd1;
                    end else begin
                        minutes_d = minutes + 6'd1;
                    end
                end else begin
                    seconds_d = seconds + 6'd1;
                end
            end else begin
                centiseconds_d = centiseconds + 7'd1;
            end
        end
    end

    // Run flag and time registers.
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            running      <= 1'b0;
            centiseconds <= '0;
            seconds      <= '0;
            minutes      <= '0;
            hours        <= '0;
        end else begin
            running      <= running_d;
            centiseconds <= centiseconds_d;
            seconds      <= seconds_d;
            minutes      <= minutes_d;
            hours        <= hours_d;
        end
    end

    // ------------------------------------------------------------------
    // Display multiplexing
    // ------------------------------------------------------------------
    function automatic logic [3:0] ones_of(input logic [6:0] v);
        ones_of = 4'(v % 7'd10);
    endfunction

    function automatic logic [3:0] tens_of(input logic [6:0] v);
        tens_of = 4'(v / 7'd10);
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'h7F;
        endcase
    endfunction

    logic [2:0] scan_q, scan_d;
    logic [3:0] digit;
    logic [6:0] seg_q, seg_d;
    logic [7:0] an_q, an_d;

    // Select the digit for the current scan slot and form the next AN/SEG pair together.
    always_comb begin
        scan_d = clock_refresh ? scan_q + 3'd1 : scan_q;
        digit  = 4'd0;
        case (scan_q)
            3'd0: digit = ones_of(centiseconds);
            3'd1: digit = tens_of(centiseconds);
            3'd2: digit = ones_of({1'b0, seconds});
            3'd3: digit = tens_of({1'b0, seconds});
            3'd4: digit = ones_of({1'b0, minutes});
            3'd5: digit = tens_of({1'b0, minutes});
            3'd6: digit = ones_of({2'b00, hours});
            3'd7: digit = tens_of({2'b00, hours});
            default: digit = 4'd0;
        endcase
        seg_d = seg_decode(digit);
        an_d  = ~(8'd1 << scan_q);
    end

    // AN and SEG share one register stage so they always change on the same edge.
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            scan_q <= '0;
            an_q   <= 8'b11111110;
            seg_q  <= 7'b1000000;
        end else begin
            scan_q <= scan_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign AN  = an_q;
    assign SEG = seg_q;

endmodule

// File: tb/tb_stopwatch_top.sv
// Directed bench for stopwatch_top with a 10-clock millisecond tick.
// Each task drives one scenario and checks hierarchical time/run state and AN/SEG.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_stopwatch_top;

    localparam int MS = 10;

    logic        clk;
    logic        rst_n;
    logic [15:0] sw;
    logic [6:0]  seg;
    logic [7:0]  an;

    int n_vec = 0;
    int n_bad = 0;

    stopwatch_top #(
        .CLK_HZ(100000000),
        .TICK_DIV(MS),
        .CS_TICKS(10),
        .DEBOUNCE_TICKS(10),
        .REFRESH_TICKS(1)
    ) dut (
        .CLK100MHZ(clk),
        .CPU_RESETN(rst_n),
        .SW(sw),
        .SEG(seg),
        .AN(an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic waitc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_an_change(output bit timed_out);
        logic [7:0] prev;
        prev = an;
        timed_out = 1'b1;
        for (int i = 0; i < 3 * MS; i++) begin
            waitc(1);
            if (an !== prev) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_an_value(input logic [7:0] v, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 12 * MS; i++) begin
            if (an === v) begin
                timed_out = 1'b0;
                break;
            end
            waitc(1);
        end
    endtask

    task automatic wait_cs_change(input logic [6:0] old, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 40 * MS; i++) begin
            waitc(1);
            if (dut.centiseconds !== old) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    // Static task: the forced right-hand sides must not be automatic variables.
    logic [4:0] p_h;
    logic [5:0] p_m, p_s;
    logic [6:0] p_cs;
    task preset_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s, input logic [6:0] cs);
        p_h = h; p_m = m; p_s = s; p_cs = cs;
        force dut.hours        = p_h;
        force dut.minutes      = p_m;
        force dut.seconds      = p_s;
        force dut.centiseconds = p_cs;
        waitc(2);
        release dut.hours;
        release dut.minutes;
        release dut.seconds;
        release dut.centiseconds;
        waitc(1);
    endtask

    task automatic press_sw0_expect(input logic exp_run, input string name);
        sw[0] = 1'b1;
        waitc(15 * MS);
        n_vec++;
        if (dut.running !== exp_run) begin
            n_bad++;
            $display("FAIL %s: running=%0b expected %0b", name, dut.running, exp_run);
        end
        sw[0] = 1'b0;
        waitc(15 * MS);
    endtask

    task automatic test_reset();
        logic [7:0] an_seq [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        bit to;
        rst_n = 1'b0;
        sw    = 16'h0000;
        waitc(5);
        rst_n = 1'b1;
        waitc(1);
        n_vec++;
        if (an !== 8'hFE || seg !== 7'b1000000) begin
            n_bad++;
            $display("FAIL reset_display: AN=%h SEG=%b expected AN=fe SEG=1000000", an, seg);
        end
        n_vec++;
        if ({dut.hours, dut.minutes, dut.seconds, dut.centiseconds, dut.running} !== 25'd0) begin
            n_bad++;
            $display("FAIL reset_state: h=%0d m=%0d s=%0d cs=%0d run=%0b expected all 0",
                     dut.hours, dut.minutes, dut.seconds, dut.centiseconds, dut.running);
        end
        for (int k = 1; k <= 8; k++) begin
            wait_an_change(to);
            n_vec++;
            if (to || an !== an_seq[k % 8] || seg !== 7'b1000000) begin
                n_bad++;
                $display("FAIL reset_scan%0d: AN=%h SEG=%b timeout=%0b expected AN=%h SEG=1000000",
                         k, an, seg, to, an_seq[k % 8]);
            end
        end
    endtask

    task automatic test_clear_idle();
        sw[1] = 1'b1;
        waitc(15 * MS);
        n_vec++;
        if (dut.running !== 1'b0 || dut.centiseconds !== 7'd0 || dut.seconds !== 6'd0) begin
            n_bad++;
            $display("FAIL clear_idle_held: run=%0b cs=%0d s=%0d expected 0 0 0",
                     dut.running, dut.centiseconds, dut.seconds);
        end
        sw[1] = 1'b0;
        waitc(15 * MS);
        n_vec++;
        if (dut.running !== 1'b0 || dut.centiseconds !== 7'd0) begin
            n_bad++;
            $display("FAIL clear_idle_release: run=%0b cs=%0d expected 0 0", dut.running, dut.centiseconds);
        end
    endtask

    task automatic test_start_stop();
        logic [6:0] c0;
        logic [6:0] frozen;
        sw[0] = 1'b1;
        waitc(5 * MS);
        n_vec++;
        if (dut.running !== 1'b0) begin
            n_bad++;
            $display("FAIL start_early: running=%0b expected 0 at 5 ms", dut.running);
        end
        waitc(10 * MS);
        n_vec++;
        if (dut.running !== 1'b1) begin
            n_bad++;
            $display("FAIL start_run: running=%0b expected 1 at 15 ms", dut.running);
        end
        sw[0] = 1'b0;
        waitc(15 * MS);
        n_vec++;
        if (dut.running !== 1'b1) begin
            n_bad++;
            $display("FAIL start_release: running=%0b expected 1 after release", dut.running);
        end
        c0 = dut.centiseconds;
        waitc(10 * MS);
        n_vec++;
        if (dut.centiseconds !== 7'(c0 + 7'd1)) begin
            n_bad++;
            $display("FAIL cs_step1: cs=%0d expected %0d", dut.centiseconds, c0 + 7'd1);
        end
        waitc(10 * MS);
        n_vec++;
        if (dut.centiseconds !== 7'(c0 + 7'd2)) begin
            n_bad++;
            $display("FAIL cs_step2: cs=%0d expected %0d", dut.centiseconds, c0 + 7'd2);
        end
        press_sw0_expect(1'b0, "stop_run");
        frozen = dut.centiseconds;
        waitc(50 * MS);
        n_vec++;
        if (dut.centiseconds !== frozen) begin
            n_bad++;
            $display("FAIL cs_frozen: cs=%0d expected %0d", dut.centiseconds, frozen);
        end
        sw[0] = 1'b1;
        waitc(15 * MS);
        n_vec++;
        if (dut.running !== 1'b1 || dut.centiseconds < frozen || dut.centiseconds > 7'(frozen + 7'd1)) begin
            n_bad++;
            $display("FAIL resume: run=%0b cs=%0d expected run=1 cs in %0d..%0d",
                     dut.running, dut.centiseconds, frozen, frozen + 7'd1);
        end
        sw[0] = 1'b0;
        waitc(15 * MS);
        c0 = dut.centiseconds;
        waitc(10 * MS);
        n_vec++;
        if (dut.centiseconds !== 7'(c0 + 7'd1)) begin
            n_bad++;
            $display("FAIL resume_step: cs=%0d expected %0d", dut.centiseconds, c0 + 7'd1);
        end
    endtask

    task automatic test_glitch();
        sw[0] = 1'b1;
        waitc(3 * MS);
        sw[0] = 1'b0;
        waitc(15 * MS);
        n_vec++;
        if (dut.running !== 1'b1) begin
            n_bad++;
            $display("FAIL glitch: running=%0b expected 1", dut.running);
        end
    endtask

    task automatic test_display();
        logic [7:0] an_seq [8]  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        logic [6:0] seg_exp [8] = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
        bit to;
        press_sw0_expect(1'b0, "display_stop");
        preset_time(5'd12, 6'd34, 6'd56, 7'd78);
        wait_an_value(8'hFE, to);
        for (int k = 0; k < 8; k++) begin
            n_vec++;
            if (to || an !== an_seq[k] || seg !== seg_exp[k]) begin
                n_bad++;
                $display("FAIL digit%0d: AN=%h SEG=%h timeout=%0b expected AN=%h SEG=%h",
                         k, an, seg, to, an_seq[k], seg_exp[k]);
            end
            if (k < 7) wait_an_change(to);
        end
        preset_time(5'd0, 6'd0, 6'd0, 7'd120);
        wait_an_value(8'hFE, to);
        n_vec++;
        if (to || seg !== 7'b1000000) begin
            n_bad++;
            $display("FAIL illegal_d0: SEG=%h timeout=%0b expected 40", seg, to);
        end
        wait_an_change(to);
        n_vec++;
        if (to || an !== 8'hFD || seg !== 7'h7F) begin
            n_bad++;
            $display("FAIL illegal_blank: AN=%h SEG=%h timeout=%0b expected AN=fd SEG=7f", an, seg, to);
        end
    endtask

    task automatic test_rollover();
        bit to;
        preset_time(5'd0, 6'd0, 6'd59, 7'd99);
        sw[0] = 1'b1;
        wait_cs_change(7'd99, to);
        n_vec++;
        if (to || dut.hours !== 5'd0 || dut.minutes !== 6'd1 || dut.seconds !== 6'd0 || dut.centiseconds !== 7'd0) begin
            n_bad++;
            $display("FAIL roll_minute: %0d:%0d:%0d.%0d timeout=%0b expected 0:1:0.0",
                     dut.hours, dut.minutes, dut.seconds, dut.centiseconds, to);
        end
        sw[0] = 1'b0;
        waitc(15 * MS);
        press_sw0_expect(1'b0, "roll_stop");
        preset_time(5'd23, 6'd59, 6'd59, 7'd99);
        sw[0] = 1'b1;
        wait_cs_change(7'd99, to);
        n_vec++;
        if (to || dut.hours !== 5'd0 || dut.minutes !== 6'd0 || dut.seconds !== 6'd0 ||
            dut.centiseconds !== 7'd0 || dut.running !== 1'b1) begin
            n_bad++;
            $display("FAIL roll_day: %0d:%0d:%0d.%0d run=%0b timeout=%0b expected 0:0:0.0 run=1",
                     dut.hours, dut.minutes, dut.seconds, dut.centiseconds, dut.running, to);
        end
        waitc(10 * MS);
        n_vec++;
        if (dut.centiseconds !== 7'd1 || dut.hours !== 5'd0) begin
            n_bad++;
            $display("FAIL roll_continue: h=%0d cs=%0d expected h=0 cs=1", dut.hours, dut.centiseconds);
        end
        sw[0] = 1'b0;
        waitc(15 * MS);
    endtask

    task automatic test_clear_running();
        logic [6:0] c0;
        n_vec++;
        if (dut.running !== 1'b1) begin
            n_bad++;
            $display("FAIL clr_pre: running=%0b expected 1", dut.running);
        end
        sw[1] = 1'b1;
        waitc(15 * MS);
        n_vec++;
        if (dut.running !== 1'b0 || dut.hours !== 5'd0 || dut.minutes !== 6'd0 ||
            dut.seconds !== 6'd0 || dut.centiseconds !== 7'd0) begin
            n_bad++;
            $display("FAIL clr_held: %0d:%0d:%0d.%0d run=%0b expected 0:0:0.0 run=0",
                     dut.hours, dut.minutes, dut.seconds, dut.centiseconds, dut.running);
        end
        sw[1] = 1'b0;
        waitc(15 * MS);
        n_vec++;
        if (dut.running !== 1'b0 || dut.centiseconds !== 7'd0) begin
            n_bad++;
            $display("FAIL clr_release: run=%0b cs=%0d expected 0 0", dut.running, dut.centiseconds);
        end
        sw[0] = 1'b1;
        waitc(15 * MS);
        n_vec++;
        if (dut.running !== 1'b1 || dut.centiseconds !== 7'd0 || dut.seconds !== 6'd0) begin
            n_bad++;
            $display("FAIL clr_restart: run=%0b s=%0d cs=%0d expected 1 0 0",
                     dut.running, dut.seconds, dut.centiseconds);
        end
        sw[0] = 1'b0;
        waitc(15 * MS);
        c0 = dut.centiseconds;
        waitc(10 * MS);
        n_vec++;
        if (dut.centiseconds !== 7'(c0 + 7'd1) || dut.seconds !== 6'd0) begin
            n_bad++;
            $display("FAIL clr_count: s=%0d cs=%0d expected s=0 cs=%0d",
                     dut.seconds, dut.centiseconds, c0 + 7'd1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sw    = 16'h0000;
        test_reset();
        test_clear_idle();
        test_start_stop();
        test_glitch();
        test_display();
        test_rollover();
        test_clear_running();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_top.md
Name: stopwatch_top

Overview:
Board-level stopwatch for a 100 MHz FPGA board. Counts HH:MM:SS.CC (hundredths of a second), with start/stop and clear driven by slide switches. Shows the time on an 8-digit multiplexed active-low seven-segment display. Top of its own design; the pins connect directly to board I/O.

Parameters:
CLK_HZ, 100000000, input clock frequency.
TICK_DIV, 100000, clocks per 1 ms tick (CLK_HZ/1000); reduced in fast simulation.
CS_TICKS, 10, 1 ms ticks per centisecond.
DEBOUNCE_TICKS, 10, consecutive stable 1 ms samples needed to accept a switch level.
REFRESH_TICKS, 1, 1 ms ticks per display digit slot.

Ports:
CLK100MHZ  input  1  system clock; all logic on its rising edge.
CPU_RESETN  input  1  synchronous active-low reset.
SW  input  16  slide switches: SW[0] start/stop toggle, SW[1] clear, SW[15:2] ignored.
SEG  output  7  segment cathodes {g,f,e,d,c,b,a}, active-low.
AN  output  8  digit anodes, active-low; AN[0] is the rightmost digit.

Behaviour:
- Reset (CPU_RESETN=0 at a clock edge):
  - all counters, dividers, debounce state and running go to 0.
  - Scan index goes to 0.
  - Next cycle AN=8'b11111110 and SEG shows "0" (7'b1000000).
- Tick generator:
  - clock_1ms is a one-cycle pulse every TICK_DIV clocks, free-running, not gated by running.
  - clock_refresh pulses every REFRESH_TICKS of clock_1ms.
  - The centisecond enable pulses every CS_TICKS of clock_1ms, only while running=1. Its prescaler holds while stopped, so no partial-period loss on resume.
- Switch input path:
  - SW[1:0] pass through a 2-FF synchronizer.
  - Each bit is sampled on clock_1ms.
  - A new level is accepted only after DEBOUNCE_TICKS equal consecutive samples.
- Start/stop:
  - A debounced 0->1 edge on SW[0] toggles running.
  - The 1->0 edge has no effect.
- Clear:
  - Debounced SW[1]=1 forces all time digits to 0 and running=0 every cycle while held.
  - Clear overrides a simultaneous start edge.
- Counting, on each centisecond enable:
  - centiseconds (7 bits) increments 0..99 and wraps to 0 with a carry to seconds.
  - seconds (6 bits) counts 0..59 with a carry to minutes.
  - minutes (6 bits) counts 0..59 with a carry to hours.
  - hours (5 bits) counts 0..23; 23:59:59.99 wraps to 00:00:00.00 and keeps running.
- Display:
  - On each clock_refresh the scan index advances 0..7 cyclically.
  - Digit mapping: digit0=cs%10, 1=cs/10, 2=s%10, 3=s/10, 4=m%10, 5=m/10, 6=h%10, 7=h/10.
  - Exactly one AN bit is low at a time, matching the scan index.
  - SEG is registered with the same latency as AN, so there is no ghosting.
  - Decimal-to-segment patterns are the standard active-low 0-9. Any illegal value blanks the digit (7'h7F).
- Internal signals clock_1ms, clock_refresh, running, centiseconds, seconds, minutes and hours keep these exact names and widths for hierarchical bench probing.

Test Plan:
1. Power-on/reset: hold CPU_RESETN=0 for 5 clocks, release -> all time fields 0, running=0, AN cycles through single-low patterns, each SEG=7'b1000000.
2. Clear at idle: pulse SW[1] high for 15 ms -> running stays 0, all fields stay 0.
3. Start then stop:
   - SW[0] high for 15 ms, low -> running=1 about 10 ms after the rising edge, centiseconds increments every 10 ms.
   - A second 15 ms pulse -> running=0 and centiseconds frozen for the next 50 ms.
   - A third pulse -> counting resumes from the frozen value.
4. Glitch rejection: SW[0] high for 3 ms, then low -> running unchanged.
5. Rollover, with TICK_DIV reduced and counters preset near limits:
   - 00:00:59.99 + 1 cs -> 00:01:00.00.
   - 23:59:59.99 -> 00:00:00.00.
6. Clear while running: SW[1] high for 15 ms mid-count -> all fields 0, running=0; after release, SW[0] pulse restarts from 00:00:00.00.
